// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle control path: opcode/funct
// constants, sequencer state encoding, instruction classes and pc_src
// encodings. Imported by mc_op_classifier, mc_sequencer and the
// combinational control decoder.
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b110000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_NOP   = 6'b111111;
   localparam logic [5:0] OP_STALL = 6'b000110;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_STALL,
      ST_HALT
   } state_t;

   // Illegal instructions are folded into CLS_NOP; the separate illegal
   // flag from the classifier carries the distinction.
   typedef enum logic [3:0] {
      CLS_ALU_R,
      CLS_ALU_I,
      CLS_BEQ,
      CLS_BNE,
      CLS_LW,
      CLS_SW,
      CLS_J,
      CLS_JR,
      CLS_NOP,
      CLS_STALL
   } iclass_t;

   typedef enum logic [1:0] {
      PC_SRC_SEQ    = 2'b00,  // PC + 4
      PC_SRC_BRANCH = 2'b01,  // branch target
      PC_SRC_JUMP   = 2'b10,  // jump target
      PC_SRC_REG    = 2'b11   // register (jr)
   } pc_src_t;

   // Classes that need an ALU cycle after DECODE.
   function automatic logic needs_exec(input iclass_t c);
      return (c == CLS_ALU_R) || (c == CLS_ALU_I) || (c == CLS_BEQ) ||
             (c == CLS_BNE)   || (c == CLS_LW)    || (c == CLS_SW);
   endfunction

endpackage

// File: rtl/mc_op_classifier.sv
// ---------------------------------------------------------------------------
// mc_op_classifier
// Combinational opcode/funct classifier.
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   iclass  out    instruction class (illegal encodings report CLS_NOP)
//   illegal out 1  unsupported opcode or R-type funct
// ---------------------------------------------------------------------------
module mc_op_classifier
   import cpu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output logic       illegal
);

   always_comb begin
      iclass  = CLS_NOP;
      illegal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_NOR, FN_AND, FN_SLL, FN_SRL: iclass = CLS_ALU_R;
               FN_JR:   iclass  = CLS_JR;
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ANDI: iclass = CLS_ALU_I;
         OP_BEQ:           iclass = CLS_BEQ;
         OP_BNE:           iclass = CLS_BNE;
         OP_LW:            iclass = CLS_LW;
         OP_SW:            iclass = CLS_SW;
         OP_J:             iclass = CLS_J;
         OP_NOP:           iclass = CLS_NOP;
         OP_STALL:         iclass = CLS_STALL;
         default:          illegal = 1'b1;  // includes jal
      endcase
   end

endmodule

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
// Multi-cycle phase sequencer (FETCH/DECODE/EXEC/MEM/WB plus STALL/HALT)
// for the single-ported datapath. Issues per-cycle strobes, handshakes with
// instruction/data memory, counts retired instructions and keeps sticky
// illegal-opcode and bus-timeout flags.
//   clk, rst        clock, synchronous active-high reset
//   opcode, funct   instruction fields, valid from DECODE onward
//   zero            ALU zero flag, used in EXEC for branches
//   mem_ready       ack for the outstanding imem_req / dmem_req
//   stall_req       external hold, honoured in FETCH only
//   imem_req, dmem_req, dmem_we           memory handshake
//   ir_write, pc_write, pc_src            IR/PC update strobes
//   aluout_write, rf_write                datapath latch strobes
//   halted, illegal_op, bus_error         status
//   instr_count     retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module mc_sequencer
   import cpu_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int STALL_CYCLES = 4,
   parameter int MEM_TIMEOUT  = 15
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             stall_req,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             aluout_write,
   output logic             rf_write,
   output logic             halted,
   output logic             illegal_op,
   output logic             bus_error,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int STALL_W = $clog2(STALL_CYCLES + 1);
   // Last count value at which a missing ack still leaves room to wait;
   // a miss here is the MEM_TIMEOUT-th unanswered cycle.
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

   state_t             state_reg, state_next;
   iclass_t            cls_reg, cls_next;
   logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
   logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               illegal_reg, illegal_next;
   logic               bus_error_reg, bus_error_next;

   iclass_t dec_class;
   logic    dec_illegal;

   // Raw strobes before reset gating
   logic    imem_req_c, dmem_req_c, dmem_we_c, ir_write_c, pc_write_c;
   logic    aluout_write_c, rf_write_c, retire;
   pc_src_t pc_src_c;

   mc_op_classifier u_classifier (
      .opcode  (opcode),
      .funct   (funct),
      .iclass  (dec_class),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_FETCH;
         cls_reg       <= CLS_NOP;
         wait_cnt_reg  <= '0;
         stall_cnt_reg <= '0;
         count_reg     <= '0;
         illegal_reg   <= 1'b0;
         bus_error_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cls_reg       <= cls_next;
         wait_cnt_reg  <= wait_cnt_next;
         stall_cnt_reg <= stall_cnt_next;
         count_reg     <= count_next;
         illegal_reg   <= illegal_next;
         bus_error_reg <= bus_error_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cls_next       = cls_reg;
      wait_cnt_next  = wait_cnt_reg;
      stall_cnt_next = stall_cnt_reg;
      illegal_next   = illegal_reg;
      bus_error_next = bus_error_reg;
      imem_req_c     = 1'b0;
      dmem_req_c     = 1'b0;
      dmem_we_c      = 1'b0;
      ir_write_c     = 1'b0;
      pc_write_c     = 1'b0;
      pc_src_c       = PC_SRC_SEQ;
      aluout_write_c = 1'b0;
      rf_write_c     = 1'b0;

      case (state_reg)
         ST_FETCH: begin
            // While held, no request is outstanding and the wait count holds.
            if (!stall_req) begin
               imem_req_c = 1'b1;
               if (mem_ready) begin
                  ir_write_c = 1'b1;
                  pc_write_c = 1'b1;
                  state_next = ST_DECODE;
               end
            end
         end

         ST_DECODE: begin
            cls_next = dec_class;
            if (dec_illegal) illegal_next = 1'b1;
            case (dec_class)
               CLS_J: begin
                  pc_write_c = 1'b1;
                  pc_src_c   = PC_SRC_JUMP;
                  state_next = ST_FETCH;
               end
               CLS_JR: begin
                  pc_write_c = 1'b1;
                  pc_src_c   = PC_SRC_REG;
                  state_next = ST_FETCH;
               end
               CLS_STALL: begin
                  stall_cnt_next = '0;
                  state_next     = ST_STALL;
               end
               default: begin
                  state_next = needs_exec(dec_class) ? ST_EXEC : ST_FETCH;
               end
            endcase
         end

         ST_EXEC: begin
            aluout_write_c = 1'b1;
            case (cls_reg)
               CLS_BEQ, CLS_BNE: begin
                  if ((cls_reg == CLS_BEQ) == zero) begin
                     pc_write_c = 1'b1;
                     pc_src_c   = PC_SRC_BRANCH;
                  end
                  state_next = ST_FETCH;
               end
               CLS_LW, CLS_SW: state_next = ST_MEM;
               default:        state_next = ST_WB;
            endcase
         end

         ST_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (cls_reg == CLS_SW);
            if (mem_ready) state_next = (cls_reg == CLS_SW) ? ST_FETCH : ST_WB;
         end

         ST_WB: begin
            rf_write_c = 1'b1;
            state_next = ST_FETCH;
         end

         ST_STALL: begin
            if (stall_cnt_reg == STALL_LAST) state_next = ST_FETCH;
            else stall_cnt_next = stall_cnt_reg + STALL_W'(1);
         end

         ST_HALT: ;

         default: state_next = ST_FETCH;
      endcase

      // Shared timeout for whichever request is outstanding. An ack on the
      // limiting cycle wins over the timeout.
      if (imem_req_c || dmem_req_c) begin
         if (mem_ready) begin
            wait_cnt_next = '0;
         end else if (wait_cnt_reg == WAIT_LAST) begin
            wait_cnt_next  = '0;
            bus_error_next = 1'b1;
            state_next     = ST_HALT;
         end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
         end
      end
   end

   // An instruction retires whenever control returns to FETCH from any
   // phase after fetch; HALT never returns and FETCH->FETCH is a wait.
   assign retire = (state_next == ST_FETCH) &&
                   (state_reg != ST_FETCH) && (state_reg != ST_HALT);
   assign count_next = count_reg + {{(CNT_W-1){1'b0}}, retire};

   // Strobes are forced low during reset so nothing fires in the reset cycle.
   assign imem_req     = imem_req_c     & ~rst;
   assign dmem_req     = dmem_req_c     & ~rst;
   assign dmem_we      = dmem_we_c      & ~rst;
   assign ir_write     = ir_write_c     & ~rst;
   assign pc_write     = pc_write_c     & ~rst;
   assign aluout_write = aluout_write_c & ~rst;
   assign rf_write     = rf_write_c     & ~rst;
   assign pc_src       = rst ? 2'b00 : pc_src_c;

   assign halted      = (state_reg == ST_HALT);
   assign illegal_op  = illegal_reg;
   assign bus_error   = bus_error_reg;
   assign instr_count = count_reg;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle sequencer for the single-ported microprocessor datapath. It drives fetch, decode, execute, memory and writeback phases, and issues per-cycle strobes for PC, IR, ALU-out latch, register file and memory. It handshakes with instruction and data memory, counts retired instructions and flags illegal opcodes and memory timeouts. It sits beside the combinational control decoder, which still supplies mux selects and ALUCtrl.

Parameters:
CNT_W, 16, width of retired-instruction counter
STALL_CYCLES, 4, cycles spent in STALL for the stall opcode (>=1)
MEM_TIMEOUT, 15, max wait cycles for mem_ready before bus error (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in EXEC
mem_ready  in  1  memory ack for the current imem_req/dmem_req
stall_req  in  1  external hold, sampled in FETCH only
imem_req  out  1  instruction read request
dmem_req  out  1  data memory request
dmem_we  out  1  data write (with dmem_req)
ir_write  out  1  load IR
pc_write  out  1  update PC
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr)
aluout_write  out  1  latch ALU result
rf_write  out  1  register-file write enable
halted  out  1  in HALT state
illegal_op  out  1  sticky: unsupported opcode/funct decoded
bus_error  out  1  sticky: memory timeout
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (synchronous, active-high): state=FETCH; instr_count=0; illegal_op=0; bus_error=0; wait and stall counters=0. Every strobe is 0 while rst=1.
- State, class register and counters are registered. Strobes are combinational from state, class, zero and mem_ready.
- FETCH:
  - stall_req=1: imem_req=0, remain in FETCH.
  - Otherwise imem_req=1.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE (1 cycle): classify opcode/funct into a registered class.
  - ALU-R: funct add 100000, sub 100010, nor 100111, and 100100, sll 000000, srl 000010.
  - ALU-I: addi 001000, andi 001100.
  - BEQ 000100, BNE 000101, LW 110000, SW 101011.
  - J 000010: pc_write=1, pc_src=10, then FETCH.
  - JR (R-type funct 001000): pc_write=1, pc_src=11, then FETCH.
  - NOP 111111: go to FETCH.
  - STALL 000110: go to STALL.
  - Anything else, including jal 000011 and unknown R funct: set illegal_op, treat as NOP.
  - ALU/branch/LW/SW classes: go to EXEC.
- EXEC (1 cycle): aluout_write=1.
  - BEQ with zero=1, or BNE with zero=0: pc_write=1, pc_src=01.
  - Branches go to FETCH. LW/SW go to MEM. ALU-R/ALU-I go to WB.
- MEM: dmem_req=1; dmem_we=1 for SW.
  - On mem_ready: SW goes to FETCH, LW goes to WB.
- WB (1 cycle): rf_write=1, then FETCH.
- STALL: hold STALL_CYCLES cycles with all strobes 0, then FETCH.
- HALT: all strobes 0, halted=1. Exit only by reset.
- Memory timeout (FETCH or MEM): wait counter increments each cycle a request is outstanding without mem_ready, and clears on ack. If it reaches MEM_TIMEOUT with no ack, set bus_error and go to HALT. An ack in the same cycle as the limit counts as success.
- Retire: instr_count += 1 on each transition into FETCH from DECODE/EXEC/MEM/WB/STALL, including NOP and illegal. Wraps at 2^CNT_W.
- Latency with mem_ready=1 in the request cycle: R/I-type 4, LW 5, SW 4, branch 3, J/JR/NOP 2, STALL 2+STALL_CYCLES.
- Reset mid-instruction: the next state is FETCH and no strobe fires in the reset cycle. A pending memory request is dropped.

Decomposition:
- Shared package cpu_pkg:
  - opcode and funct constants
  - state enum (FETCH, DECODE, EXEC, MEM, WB, STALL, HALT)
  - instruction class enum
  - pc_src encodings
- One sub-module, mc_op_classifier: combinational opcode/funct to class plus illegal flag, reusable by the existing decoder.

Test Plan:
- add (op 000000, funct 100000), mem_ready always 1 -> strobes over 4 cycles: imem_req+ir_write+pc_write, -, aluout_write, rf_write. instr_count=1.
- beq with zero=1, then bne with zero=1 -> first gives pc_write=1, pc_src=01 in EXEC; second gives no pc_write in EXEC. Each takes 3 cycles.
- lw (110000) with mem_ready delayed 3 cycles in MEM -> dmem_req high 4 cycles, dmem_we=0, rf_write one cycle later. sw gives dmem_we=1 and no rf_write.
- opcode 000011 (jal) -> illegal_op=1 stays set, returns to FETCH after DECODE, instr_count increments. rst clears illegal_op.
- FETCH with mem_ready held 0, MEM_TIMEOUT=15 -> bus_error=1 and halted=1 after 15 cycles. Strobes stay 0 until rst.
- stall opcode 000110 with STALL_CYCLES=4 -> 4 idle cycles, then imem_req. stall_req=1 in FETCH holds imem_req=0. rst asserted in MEM -> FETCH next cycle, counters 0.
